// File: rtl/glb_ctrl_pkg.sv
// Shared definitions for the depthwise-layer sequencer: state encoding and
// per-channel address strides.
package glb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        COMP,
        NEXT,
        DONE
    } seq_state_t;

    localparam int DEF_IW    = 32;
    localparam int DEF_IH    = 32;
    localparam int DEF_KSIZE = 3;

    localparam int MAP_WORDS = DEF_IW * DEF_IH;
    localparam int KER_WORDS = DEF_KSIZE * DEF_KSIZE;

    // Stride helpers so a non-default geometry derives its own increments.
    function automatic int map_words(input int iw, input int ih);
        return iw * ih;
    endfunction

    function automatic int ker_words(input int ksize);
        return ksize * ksize;
    endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Command and data_path handshake bundle of the sequencer; slave is the
// sequencer side, master is the host / data_path side.
interface datapath_seq_if #(
    parameter int AW = 32,
    parameter int CW = 16
);
    logic          start;
    logic          abort;
    logic [CW-1:0] num_ch;
    logic [AW-1:0] data_base;
    logic [AW-1:0] wt_base;
    logic          blkend;
    logic          mapend;
    logic          result_valid;
    logic          data_load;
    logic          dw_comp;
    logic          data_init_addr_en;
    logic [AW-1:0] data_init_addr;
    logic [AW-1:0] weight_init_addr;
    logic [CW-1:0] ch_idx;
    logic          busy;
    logic          done;

    modport slave (
        input  start, abort, num_ch, data_base, wt_base,
               blkend, mapend, result_valid,
        output data_load, dw_comp, data_init_addr_en, data_init_addr,
               weight_init_addr, ch_idx, busy, done
    );

    modport master (
        output start, abort, num_ch, data_base, wt_base,
               blkend, mapend, result_valid,
        input  data_load, dw_comp, data_init_addr_en, data_init_addr,
               weight_init_addr, ch_idx, busy, done
    );
endinterface

// File: rtl/seq_addr_gen.sv
// Channel counter and per-channel feature-map / weight address registers.
module seq_addr_gen #(
    parameter int            AW      = 32,
    parameter int            CW      = 16,
    parameter logic [AW-1:0] MAP_INC = '0,
    parameter logic [AW-1:0] KER_INC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] data_base,
    input  logic [AW-1:0] wt_base,
    output logic [CW-1:0] ch_idx,
    output logic [AW-1:0] data_addr,
    output logic [AW-1:0] wt_addr
);

    // Additions wrap modulo 2^AW on purpose; buffers may sit at the top of memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx    <= '0;
            data_addr <= '0;
            wt_addr   <= '0;
        end else if (load) begin
            ch_idx    <= '0;
            data_addr <= data_base;
            wt_addr   <= wt_base;
        end else if (step) begin
            ch_idx    <= ch_idx + CW'(1);
            data_addr <= data_addr + MAP_INC;
            wt_addr   <= wt_addr + KER_INC;
        end
    end

endmodule

// File: rtl/datapath_seq.sv
// Depthwise layer sequencer: walks num_ch channels, alternating block loads and
// compute phases on data_path until each map ends.
module datapath_seq
    import glb_ctrl_pkg::*;
#(
    parameter int AW    = 32,
    parameter int IW    = 32,
    parameter int IH    = 32,
    parameter int KSIZE = 3,
    parameter int CW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    datapath_seq_if.slave  bus
);

    localparam logic [AW-1:0] MAP_INC = AW'(map_words(IW, IH));
    localparam logic [AW-1:0] KER_INC = AW'(ker_words(KSIZE));

    seq_state_t    state;
    logic [CW-1:0] num_ch_q;
    logic [CW-1:0] ch_idx;
    logic [CW-1:0] ch_next;
    logic [AW-1:0] data_addr;
    logic [AW-1:0] wt_addr;
    logic          map_flag;
    logic          data_load_q;
    logic          dw_comp_q;
    logic          addr_en_q;
    logic          busy_q;
    logic          done_q;
    logic          addr_load;
    logic          addr_step;

    assign addr_load = (state == IDLE) && bus.start && !bus.abort;
    assign addr_step = (state == NEXT) && !bus.abort;
    assign ch_next   = ch_idx + CW'(1);

    seq_addr_gen #(
        .AW      (AW),
        .CW      (CW),
        .MAP_INC (MAP_INC),
        .KER_INC (KER_INC)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (addr_load),
        .step      (addr_step),
        .data_base (bus.data_base),
        .wt_base   (bus.wt_base),
        .ch_idx    (ch_idx),
        .data_addr (data_addr),
        .wt_addr   (wt_addr)
    );

    // Outputs are set on the edge that enters their state, so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_ch_q    <= '0;
            map_flag    <= 1'b0;
            data_load_q <= 1'b0;
            dw_comp_q   <= 1'b0;
            addr_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_en_q <= 1'b0;
            done_q    <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                data_load_q <= 1'b0;
                dw_comp_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            num_ch_q <= bus.num_ch;
                            busy_q   <= 1'b1;
                            if (bus.num_ch != '0) begin
                                state     <= INIT;
                                addr_en_q <= 1'b1;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    INIT: begin
                        state       <= LOAD;
                        map_flag    <= 1'b0;
                        data_load_q <= 1'b1;
                    end
                    LOAD: begin
                        if (bus.mapend) map_flag <= 1'b1;
                        if (bus.blkend) begin
                            state       <= COMP;
                            data_load_q <= 1'b0;
                            dw_comp_q   <= 1'b1;
                        end
                    end
                    // A mapend arriving alongside result_valid still ends this map.
                    COMP: begin
                        if (bus.mapend) map_flag <= 1'b1;
                        if (bus.result_valid) begin
                            dw_comp_q <= 1'b0;
                            if (map_flag || bus.mapend) begin
                                state <= NEXT;
                            end else begin
                                state       <= LOAD;
                                data_load_q <= 1'b1;
                            end
                        end
                    end
                    NEXT: begin
                        if (ch_next == num_ch_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= INIT;
                            addr_en_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state       <= IDLE;
                        data_load_q <= 1'b0;
                        dw_comp_q   <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_load         = data_load_q;
    assign bus.dw_comp           = dw_comp_q;
    assign bus.data_init_addr_en = addr_en_q;
    assign bus.data_init_addr    = data_addr;
    assign bus.weight_init_addr  = wt_addr;
    assign bus.ch_idx            = ch_idx;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a small data_path responder answers LOAD and
// COMP phases while the expected addresses and counts are hand-computed.
module tb_datapath_seq;

    logic clk;
    logic rst;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] dAddrQ[$];
    logic [31:0] wAddrQ[$];
    logic [15:0] chQ[$];

    datapath_seq_if #(.AW(32), .CW(16)) bus ();

    datapath_seq #(
        .AW(32), .IW(32), .IH(32), .KSIZE(3), .CW(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.blkend       = 1'b0;
        bus.mapend       = 1'b0;
        bus.result_valid = 1'b0;
    endtask

    // Leaves the caller on the negedge right after start was sampled.
    task automatic startLayer(input int nc, input logic [31:0] db, input logic [31:0] wb);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_ch    = 16'(nc);
        bus.data_base = db;
        bus.wt_base   = wb;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Responder: every LOAD and COMP lasts one cycle; mapend marks the last block.
    task automatic applyStimulus(input int blocks, input bit sameCycle, input int abortCh,
                                 input bit pokeStart, output int inits, output int loads,
                                 output int comps, output int dones, output int overlaps);
        int  blk = 0;
        bit  finished = 0;
        bit  aborted = 0;
        inits = 0; loads = 0; comps = 0; dones = 0; overlaps = 0;
        dAddrQ.delete(); wAddrQ.delete(); chQ.delete();
        for (int i = 0; i < 400; i++) begin
            clearInputs();
            if (bus.data_init_addr_en) begin
                dAddrQ.push_back(bus.data_init_addr);
                wAddrQ.push_back(bus.weight_init_addr);
                chQ.push_back(bus.ch_idx);
                blk = 0;
                inits++;
            end
            if (bus.data_load && bus.dw_comp) overlaps++;
            if (bus.data_load) begin
                loads++;
                bus.blkend = 1'b1;
                if (sameCycle && blk == blocks - 1) bus.mapend = 1'b1;
                if (pokeStart && loads == 1) begin
                    bus.start     = 1'b1;
                    bus.num_ch    = 16'd7;
                    bus.data_base = 32'hDEAD_0000;
                    bus.wt_base   = 32'hBEEF_0000;
                end
            end
            if (bus.dw_comp) begin
                if (abortCh >= 0 && int'(bus.ch_idx) == abortCh) begin
                    bus.abort = 1'b1;
                    aborted = 1;
                end else begin
                    bus.result_valid = 1'b1;
                    comps++;
                    if (!sameCycle && blk == blocks - 1) bus.mapend = 1'b1;
                    blk++;
                end
            end
            if (bus.done) begin
                dones++;
                finished = 1;
            end
            if (finished || aborted) break;
            @(negedge clk);
        end
        if (!finished && !aborted) checkOutput("layer_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int inits, loads, comps, dones, overlaps, doneSeen;
        bus.num_ch    = '0;
        bus.data_base = '0;
        bus.wt_base   = '0;
        clearInputs();
        rst = 1'b1;

        #12;
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_load_comp_en", {bus.data_load, bus.dw_comp, bus.data_init_addr_en}, 0);
        checkOutput("rst_ch_idx", bus.ch_idx, 0);
        checkOutput("rst_addrs", {bus.data_init_addr, bus.weight_init_addr}, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] two channels, three blocks per map");
        startLayer(2, 32'h0000_1000, 32'h0000_0200);
        checkOutput("busy_after_start", bus.busy, 1);
        applyStimulus(3, 0, -1, 0, inits, loads, comps, dones, overlaps);
        checkOutput("l1_inits", inits, 2);
        checkOutput("l1_daddr0", dAddrQ[0], 32'h0000_1000);
        checkOutput("l1_waddr0", wAddrQ[0], 32'h0000_0200);
        checkOutput("l1_daddr1", dAddrQ[1], 32'h0000_1400);
        checkOutput("l1_waddr1", wAddrQ[1], 32'h0000_0209);
        checkOutput("l1_ch_seq", {chQ[0], chQ[1]}, {16'd0, 16'd1});
        checkOutput("l1_loads", loads, 6);
        checkOutput("l1_comps", comps, 6);
        checkOutput("l1_overlap", overlaps, 0);
        checkOutput("l1_ch_at_done", bus.ch_idx, 2);
        @(negedge clk);
        checkOutput("l1_done_single", bus.done, 0);
        checkOutput("l1_idle_busy", bus.busy, 0);

        $display("[TB] zero channels");
        startLayer(0, 32'h0000_7000, 32'h0000_0700);
        checkOutput("z_done", bus.done, 1);
        checkOutput("z_addr_en", bus.data_init_addr_en, 0);
        @(negedge clk);
        checkOutput("z_done_drop", bus.done, 0);
        checkOutput("z_busy", bus.busy, 0);
        checkOutput("z_addr_en2", bus.data_init_addr_en, 0);

        $display("[TB] mapend together with blkend");
        startLayer(1, 32'h0000_2000, 32'h0000_0100);
        applyStimulus(3, 1, -1, 0, inits, loads, comps, dones, overlaps);
        checkOutput("sc_loads", loads, 3);
        checkOutput("sc_comps", comps, 3);
        checkOutput("sc_dones", dones, 1);

        $display("[TB] address wrap");
        startLayer(2, 32'hFFFF_FC00, 32'h0000_0000);
        applyStimulus(1, 0, -1, 0, inits, loads, comps, dones, overlaps);
        checkOutput("wrap_daddr1", dAddrQ[1], 32'h0000_0000);
        checkOutput("wrap_waddr1", wAddrQ[1], 32'h0000_0009);

        $display("[TB] abort during channel 1 compute");
        startLayer(4, 32'h0000_4000, 32'h0000_0400);
        applyStimulus(2, 0, 1, 0, inits, loads, comps, dones, overlaps);
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("ab_busy", bus.busy, 0);
        checkOutput("ab_comp", bus.dw_comp, 0);
        checkOutput("ab_load", bus.data_load, 0);
        doneSeen = dones;
        for (int i = 0; i < 5; i++) begin
            if (bus.done) doneSeen++;
            @(negedge clk);
        end
        checkOutput("ab_no_done", doneSeen, 0);
        startLayer(1, 32'h0000_3000, 32'h0000_0040);
        applyStimulus(1, 0, -1, 0, inits, loads, comps, dones, overlaps);
        checkOutput("ab_restart_ch", chQ[0], 0);
        checkOutput("ab_restart_addr", dAddrQ[0], 32'h0000_3000);
        checkOutput("ab_restart_done", dones, 1);

        $display("[TB] start while busy");
        startLayer(1, 32'h0000_5000, 32'h0000_0080);
        applyStimulus(2, 0, -1, 1, inits, loads, comps, dones, overlaps);
        checkOutput("sb_inits", inits, 1);
        checkOutput("sb_loads", loads, 2);
        checkOutput("sb_daddr", dAddrQ[0], 32'h0000_5000);
        @(negedge clk);
        checkOutput("sb_idle", bus.busy, 0);

        $display("[TB] reset in LOAD");
        startLayer(1, 32'h0000_6000, 32'h0000_0090);
        @(negedge clk);
        checkOutput("rl_in_load", bus.data_load, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rl_load", bus.data_load, 0);
        checkOutput("rl_busy", bus.busy, 0);
        checkOutput("rl_addr", bus.data_init_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 5; i++) begin
            bus.blkend = 1'b1;
            bus.result_valid = 1'b1;
            if (bus.done || bus.busy) doneSeen++;
            @(negedge clk);
        end
        clearInputs();
        checkOutput("rl_stay_idle", doneSeen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 Parameter AW, 32, address width of data_init_addr and weight_init_addr.
REQ-002 Parameter IW, 32, input feature-map width in words.
REQ-003 Parameter IH, 32, input feature-map height in words.
REQ-004 Parameter KSIZE, 3, kernel edge length.
REQ-005 Parameter CW, 16, channel-count width.
REQ-006 Ports, one per line:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to run a layer; sampled only in IDLE.
- abort  input  1  forces return to IDLE.
- num_ch  input  CW  depthwise channel count; sampled on accepted start.
- data_base  input  AW  feature-map base address; sampled on accepted start.
- wt_base  input  AW  weight base address; sampled on accepted start.
- blkend  input  1  data_path has finished loading the current block.
- mapend  input  1  data_path has finished the last block of the current map.
- result_valid  input  1  first PE result valid (result_valid[0][0]).
- data_load  output  1  load-phase enable to data_path.
- dw_comp  output  1  compute-phase enable to data_path.
- data_init_addr_en  output  1  one-cycle address-load strobe.
- data_init_addr  output  AW  current channel feature-map address.
- weight_init_addr  output  AW  current channel weight address.
- ch_idx  output  CW  index of the channel in progress.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle layer-complete pulse.

Function
REQ-007 The FSM shall have states IDLE, INIT, LOAD, COMP, NEXT and DONE; all outputs shall be decoded from registered state and registers only, with no combinational input-to-output path.
REQ-008 IDLE: start with num_ch != 0 -> INIT; start with num_ch == 0 -> DONE without any data_init_addr_en.
REQ-009 INIT shall last exactly one cycle, assert data_init_addr_en with both addresses valid in that cycle, and go to LOAD.
REQ-010 LOAD shall hold data_load=1 until blkend is sampled high, then go to COMP on the next edge.
REQ-011 COMP shall hold dw_comp=1 until result_valid is sampled high, then go to NEXT if the mapend flag is set, otherwise back to LOAD.
REQ-012 The mapend flag shall be set by mapend seen in LOAD or COMP, including the same cycle as blkend or result_valid, and cleared in INIT.
REQ-013 NEXT shall increment ch_idx, add IW*IH to data_init_addr and KSIZE*KSIZE to weight_init_addr, then go to DONE if the new ch_idx equals num_ch, else to INIT.
REQ-014 Address arithmetic shall be unsigned modulo 2^AW; wrap-around is legal and silent.
REQ-015 DONE shall assert done for exactly one cycle, then go to IDLE.
REQ-016 start outside IDLE shall be ignored; base inputs and num_ch changing mid-layer shall have no effect.
REQ-017 abort in any state shall move to IDLE on the next edge, deassert all strobes, and raise no done pulse; abort has priority over every other transition.
REQ-018 data_load and dw_comp shall never be high in the same cycle.

Reset
REQ-019 While rst is high: state=IDLE; data_load, dw_comp, data_init_addr_en, busy, done = 0; ch_idx, data_init_addr, weight_init_addr = 0; mapend flag = 0.
REQ-020 Reset asserted mid-layer shall take effect immediately, without waiting for a clock edge, and no done pulse shall follow.

Structure
REQ-021 The state enumeration and derived constants MAP_WORDS=IW*IH and KER_WORDS=KSIZE*KSIZE shall live in shared package glb_ctrl_pkg.
REQ-022 A single sub-module, seq_addr_gen, shall hold ch_idx and the two address registers, controlled by load and step inputs.

Verification
REQ-023 num_ch=2, data_base=0x1000, wt_base=0x200, 3 blocks/map -> INIT addresses (0x1000, 0x200) then (0x1400, 0x209); 6 LOAD/COMP pairs; single done.
REQ-024 num_ch=0 with start -> done one cycle after the IDLE sample; data_init_addr_en never high.
REQ-025 mapend in the same cycle as blkend -> COMP once, then NEXT; no further LOAD for that channel.
REQ-026 data_base=0xFFFF_FC00, num_ch=2 -> second data_init_addr=0x0000_0000.
REQ-027 abort during COMP of channel 1 of 4 -> IDLE next cycle, dw_comp=0, done never pulses; a new start restarts at ch_idx=0.
REQ-028 rst asserted during LOAD mid-cycle -> all outputs 0 before the next clk edge; start pulsed while busy -> ignored.
